// File: rtl/reg_access_master_if.sv
// Bundles the reg_access_master command, response and device-register signals.
// master: the sequencer's view; slave: the host/device environment's view.
interface reg_access_master_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_mismatch;
  logic [ADDR_W-1:0] dev_address;
  logic              dev_write_en;
  logic              dev_read_en;
  logic [DATA_W-1:0] dev_data_in;
  logic [DATA_W-1:0] dev_read_data;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, dev_read_data,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_mismatch,
    output dev_address, dev_write_en, dev_read_en, dev_data_in, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, dev_read_data,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_mismatch,
    input  dev_address, dev_write_en, dev_read_en, dev_data_in, busy
  );
endinterface

// File: rtl/reg_access_master.sv
// Command sequencer for the 4-register device block: FIFO-buffered commands, one response each.
// Define RDBK_CHECK_EN to read back every write and flag rsp_mismatch.
module reg_access_master #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned CMD_DEPTH = 2
) (
  input logic             clk,
  input logic             resetb,
  reg_access_master_if.master bus
);

  localparam int unsigned PtrW = $clog2(CMD_DEPTH);
  localparam logic [ADDR_W:0] NumRegsW = NUM_REGS[ADDR_W:0];
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdWait, StResp} state_e;

  entry_t          mem_q [CMD_DEPTH];
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic            full, empty, push, pop;
  entry_t          head;

  state_e            state_q;
  logic [ADDR_W-1:0] dev_addr_q;
  logic [DATA_W-1:0] dev_data_q;
  logic              wr_en_q, rd_en_q;
  logic              rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
`ifdef RDBK_CHECK_EN
  logic              rsp_mismatch_q;
`endif

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state_q == StIdle) && !empty;
  assign head  = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= '{write: bus.cmd_write, addr: bus.cmd_addr,
                                     wdata: bus.cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q        <= StIdle;
      dev_addr_q     <= '0;
      dev_data_q     <= '0;
      wr_en_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
`ifdef RDBK_CHECK_EN
      rsp_mismatch_q <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            dev_addr_q  <= head.addr;
            dev_data_q  <= head.wdata;
            rsp_write_q <= head.write;
            rsp_rdata_q <= '0;
`ifdef RDBK_CHECK_EN
            rsp_mismatch_q <= 1'b0;
`endif
            if ({1'b0, head.addr} >= NumRegsW) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else if (head.write) begin
              rsp_err_q <= 1'b0;
              wr_en_q   <= 1'b1;
              state_q   <= StWr;
            end else begin
              rsp_err_q <= 1'b0;
              rd_en_q   <= 1'b1;
              state_q   <= StRd;
            end
          end
        end
        StWr: begin
`ifdef RDBK_CHECK_EN
          rd_en_q <= 1'b1;
          state_q <= StRd;
`else
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
`endif
        end
        StRd: state_q <= StRdWait;
        StRdWait: begin
          rsp_rdata_q <= bus.dev_read_data;
`ifdef RDBK_CHECK_EN
          rsp_mismatch_q <= rsp_write_q && (bus.dev_read_data != dev_data_q);
`endif
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready    = !full;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_write    = rsp_write_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
`ifdef RDBK_CHECK_EN
  assign bus.rsp_mismatch = rsp_mismatch_q;
`else
  assign bus.rsp_mismatch = 1'b0;
`endif
  assign bus.dev_address  = dev_addr_q;
  assign bus.dev_data_in  = dev_data_q;
  assign bus.dev_write_en = wr_en_q;
  assign bus.dev_read_en  = rd_en_q;
  assign bus.busy         = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master with a 4-register device model behind the register port.
// Expectations follow the RDBK_CHECK_EN setting of the build.
module tb_reg_access_master;

`ifdef RDBK_CHECK_EN
  localparam bit Rdbk = 1'b1;
`else
  localparam bit Rdbk = 1'b0;
`endif
  localparam int WrLat = Rdbk ? 4 : 2;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  reg_access_master_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  reg_access_master #(.ADDR_W(4), .DATA_W(8), .NUM_REGS(4), .CMD_DEPTH(2)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  // Device register block: registered read data, reset with the sequencer.
  logic [7:0] dev_regs [4];
  logic [7:0] dev_rd_q;
  logic       force_zero = 1'b0;
  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 4; i++) dev_regs[i] <= 8'h00;
      dev_rd_q <= 8'h00;
    end else begin
      if (bus.dev_write_en && bus.dev_address < 4) dev_regs[bus.dev_address[1:0]] <= bus.dev_data_in;
      if (bus.dev_read_en) dev_rd_q <= (bus.dev_address < 4) ? dev_regs[bus.dev_address[1:0]] : 8'h00;
    end
  end
  assign bus.dev_read_data = force_zero ? 8'h00 : dev_rd_q;

  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [3:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [7:0] last_wr_data = '0;
  always @(posedge clk) begin
    if (bus.dev_write_en) begin
      wr_cnt <= wr_cnt + 1;
      last_wr_addr <= bus.dev_address;
      last_wr_data <= bus.dev_data_in;
    end
    if (bus.dev_read_en) begin
      rd_cnt <= rd_cnt + 1;
      last_rd_addr <= bus.dev_address;
    end
    if (bus.dev_write_en && bus.dev_read_en) both_cnt <= both_cnt + 1;
  end

  int n_vec = 0, n_err = 0;

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d);
    bit acc = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    for (int i = 0; i < 100; i++) begin
      if (bus.cmd_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++;
    if (!acc) begin n_err++; $display("FAIL push_timeout: cmd_ready=%b want 1", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for a response, counts negedges waited, completes the handshake.
  task automatic get_rsp(output logic w, output logic [7:0] d, output logic e, output logic m,
                         output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    w = bus.rsp_write; d = bus.rsp_rdata; e = bus.rsp_err; m = bus.rsp_mismatch;
    @(negedge clk);
  endtask

  logic rw, re, rm;
  logic [7:0] rd;
  int lat;
  bit ok;

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.rsp_ready = 1;
    resetb = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_vec++; if ({bus.dev_address, bus.dev_data_in, bus.dev_write_en, bus.dev_read_en} !== 14'h0)
      begin n_err++; $display("FAIL rst_dev: got %h/%h/%b/%b want 0", bus.dev_address, bus.dev_data_in, bus.dev_write_en, bus.dev_read_en); end
    n_vec++; if ({bus.busy, bus.rsp_write, bus.rsp_err, bus.rsp_mismatch, bus.rsp_rdata} !== 12'h0)
      begin n_err++; $display("FAIL rst_rsp: got busy=%b w=%b e=%b m=%b d=%h want 0", bus.busy, bus.rsp_write, bus.rsp_err, bus.rsp_mismatch, bus.rsp_rdata); end
    resetb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int w0 = wr_cnt, r0 = rd_cnt;
    push(1'b1, 4'd2, 8'hA5);
    get_rsp(rw, rd, re, rm, lat, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wr_timeout: rsp_valid=0 want 1"); end
    n_vec++; if (lat != WrLat) begin n_err++; $display("FAIL wr_latency: got %0d want %0d", lat, WrLat); end
    n_vec++; if ({rw, re, rm} !== 3'b100) begin n_err++; $display("FAIL wr_flags: got w=%b e=%b m=%b want 1/0/0", rw, re, rm); end
    n_vec++; if (rd !== (Rdbk ? 8'hA5 : 8'h00)) begin n_err++; $display("FAIL wr_rdata: got %h want %h", rd, Rdbk ? 8'hA5 : 8'h00); end
    n_vec++; if (wr_cnt - w0 != 1) begin n_err++; $display("FAIL wr_pulses: got %0d want 1", wr_cnt - w0); end
    n_vec++; if ({last_wr_addr, last_wr_data} !== 12'h2A5) begin n_err++; $display("FAIL wr_bus: got %h/%h want 2/a5", last_wr_addr, last_wr_data); end
    push(1'b0, 4'd2, 8'h00);
    get_rsp(rw, rd, re, rm, lat, ok);
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_vec++; if (rd !== 8'hA5) begin n_err++; $display("FAIL rd_data: got %h want a5", rd); end
    n_vec++; if ({rw, re, rm} !== 3'b000) begin n_err++; $display("FAIL rd_flags: got w=%b e=%b m=%b want 0/0/0", rw, re, rm); end
    n_vec++; if (rd_cnt - r0 != (Rdbk ? 2 : 1)) begin n_err++; $display("FAIL rd_pulses: got %0d want %0d", rd_cnt - r0, Rdbk ? 2 : 1); end
  endtask

  task automatic test_error();
    int w0 = wr_cnt, r0 = rd_cnt;
    push(1'b1, 4'd7, 8'hFF);
    get_rsp(rw, rd, re, rm, lat, ok);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL err_latency: got %0d want 1", lat); end
    n_vec++; if ({rw, re, rm} !== 3'b110) begin n_err++; $display("FAIL err_flags: got w=%b e=%b m=%b want 1/1/0", rw, re, rm); end
    n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL err_rdata: got %h want 00", rd); end
    n_vec++; if (wr_cnt != w0 || rd_cnt != r0) begin n_err++; $display("FAIL err_strobes: got wr=%0d rd=%0d want 0/0", wr_cnt - w0, rd_cnt - r0); end
    push(1'b0, 4'd0, 8'h00);
    get_rsp(rw, rd, re, rm, lat, ok);
    n_vec++; if ({re, rd} !== 9'h000) begin n_err++; $display("FAIL err_next_read: got e=%b d=%h want 0/00", re, rd); end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt, r0 = rd_cnt;
    bus.rsp_ready = 1'b0;
    push(1'b1, 4'd3, 8'h77);
    push(1'b0, 4'd3, 8'h00);
    push(1'b0, 4'd2, 8'h00);
    n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: cmd_ready got %b want 0", bus.cmd_ready); end
    repeat (6) @(negedge clk);
    n_vec++; if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_write, bus.busy} !== 4'b0111)
      begin n_err++; $display("FAIL b2b_stall: got ready=%b valid=%b w=%b busy=%b want 0/1/1/1", bus.cmd_ready, bus.rsp_valid, bus.rsp_write, bus.busy); end
    get_rsp(rw, rd, re, rm, lat, ok);
    n_vec++; if ({rw, re, rd} !== {2'b10, Rdbk ? 8'h77 : 8'h00}) begin n_err++; $display("FAIL b2b_rsp0: got w=%b e=%b d=%h", rw, re, rd); end
    get_rsp(rw, rd, re, rm, lat, ok);
    n_vec++; if ({rw, re, rd} !== {2'b00, 8'h77}) begin n_err++; $display("FAIL b2b_rsp1: got w=%b e=%b d=%h want 0/0/77", rw, re, rd); end
    get_rsp(rw, rd, re, rm, lat, ok);
    n_vec++; if ({rw, re, rd} !== {2'b00, 8'hA5}) begin n_err++; $display("FAIL b2b_rsp2: got w=%b e=%b d=%h want 0/0/a5", rw, re, rd); end
    n_vec++; if (wr_cnt - w0 != 1 || rd_cnt - r0 != (Rdbk ? 3 : 2))
      begin n_err++; $display("FAIL b2b_strobes: got wr=%0d rd=%0d want 1/%0d", wr_cnt - w0, rd_cnt - r0, Rdbk ? 3 : 2); end
  endtask

  task automatic test_fill_all();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 4'(i), vals[i]);
      get_rsp(rw, rd, re, rm, lat, ok);
      n_vec++; if ({rw, re, rm} !== 3'b100) begin n_err++; $display("FAIL fill_wr%0d: got w=%b e=%b m=%b want 1/0/0", i, rw, re, rm); end
    end
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 4'(i), 8'h00);
      get_rsp(rw, rd, re, rm, lat, ok);
      n_vec++; if (rd !== vals[i]) begin n_err++; $display("FAIL fill_rd%0d: got %h want %h", i, rd, vals[i]); end
    end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL fill_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int r0 = rd_cnt;
    int seen = 0;
    push(1'b0, 4'd2, 8'h00);
    repeat (2) @(negedge clk);
    n_vec++; if (rd_cnt - r0 != 1) begin n_err++; $display("FAIL mid_rd_pulse: got %0d want 1", rd_cnt - r0); end
    resetb = 1'b0;
    #1;
    n_vec++; if ({bus.rsp_valid, bus.dev_read_en, bus.dev_write_en, bus.busy, bus.cmd_ready} !== 5'b00001)
      begin n_err++; $display("FAIL mid_ctrl: got v=%b re=%b we=%b busy=%b rdy=%b want 0/0/0/0/1", bus.rsp_valid, bus.dev_read_en, bus.dev_write_en, bus.busy, bus.cmd_ready); end
    n_vec++; if ({bus.dev_address, bus.dev_data_in, bus.rsp_rdata} !== 20'h0)
      begin n_err++; $display("FAIL mid_data: got a=%h di=%h rd=%h want 0", bus.dev_address, bus.dev_data_in, bus.rsp_rdata); end
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL mid_no_rsp: got %0d valid cycles want 0", seen); end
    push(1'b0, 4'd0, 8'h00);
    get_rsp(rw, rd, re, rm, lat, ok);
    n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL mid_dev_reset: got %h want 00", rd); end
  endtask

`ifdef RDBK_CHECK_EN
  task automatic test_readback();
    int r0 = rd_cnt;
    push(1'b1, 4'd1, 8'h5A);
    get_rsp(rw, rd, re, rm, lat, ok);
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL rb_latency: got %0d want 4", lat); end
    n_vec++; if ({rd, rm} !== {8'h5A, 1'b0}) begin n_err++; $display("FAIL rb_match: got d=%h m=%b want 5a/0", rd, rm); end
    n_vec++; if (rd_cnt - r0 != 1 || last_rd_addr !== 4'd1) begin n_err++; $display("FAIL rb_strobe: got n=%0d a=%h want 1/1", rd_cnt - r0, last_rd_addr); end
    force_zero = 1'b1;
    push(1'b1, 4'd1, 8'h5A);
    get_rsp(rw, rd, re, rm, lat, ok);
    force_zero = 1'b0;
    n_vec++; if ({rd, rm} !== {8'h00, 1'b1}) begin n_err++; $display("FAIL rb_mismatch: got d=%h m=%b want 00/1", rd, rm); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_error();
    test_back_to_back();
    test_fill_all();
    test_reset_mid();
`ifdef RDBK_CHECK_EN
    test_readback();
`endif
    n_vec++; if (both_cnt != 0) begin n_err++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
